// File: rtl/interface_pkg.sv
// interface_pkg
// Shared constants for the 10-bit <-> 16-bit data interface gearbox.
// Used by the transmit-side packer (interface_packer) and by the
// receive-side unpacker, so both ends agree on widths and frame shape.
//   IN_W_DEFAULT       sample width (10)
//   OUT_W_DEFAULT      link word width (16)
//   SAMPLES_PER_FRAME  samples that exactly fill one frame (8)
//   WORDS_PER_FRAME    link words in one frame (5)
//   COUNT_W            width of the held-bit counter (0..25 -> 5 bits)
package interface_pkg;

  localparam int IN_W_DEFAULT      = 10;
  localparam int OUT_W_DEFAULT     = 16;
  localparam int SAMPLES_PER_FRAME = 8;
  localparam int WORDS_PER_FRAME   = 5;

  // The accumulator holds at most IN_W+OUT_W-1 bits, so the counter must
  // reach that value; IN_W+OUT_W values fit in clog2(IN_W+OUT_W) bits.
  function automatic int count_width(input int in_w, input int out_w);
    return $clog2(in_w + out_w);
  endfunction

  localparam int COUNT_W = count_width(IN_W_DEFAULT, OUT_W_DEFAULT);

endpackage

// File: rtl/interface_packer_acc.sv
// interface_packer_acc
// Accumulator register and bit counter of the 10->16 packer.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   accept      a sample is written into the accumulator this cycle
//   emit        the low OUT_W bits leave as a link word this cycle
//   pad         round a partial word up to OUT_W bits (zero padded)
//   in_data     sample to insert at bit position count
//   word        acc[OUT_W-1:0], the candidate output word
//   count       number of valid bits currently held
module interface_packer_acc
  import interface_pkg::*;
#(
  parameter int IN_W  = IN_W_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT,
  parameter int ACC_W = IN_W + OUT_W - 1,
  parameter int CNT_W = count_width(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic             emit,
  input  logic             pad,
  input  logic [IN_W-1:0]  in_data,
  output logic [OUT_W-1:0] word,
  output logic [CNT_W-1:0] count
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_shifted;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] count_shifted;
  logic [CNT_W-1:0] count_next;

  assign word = acc[OUT_W-1:0];

  // Next accumulator state: the outgoing word is shifted out first, then the
  // new sample lands just above the bits that remain. Bits above count are
  // always zero, so OR-ing the shifted sample in is a clean insert. Padding
  // only moves the counter; the zero bits above the partial word become the pad.
  always_comb begin
    acc_shifted   = acc;
    count_shifted = count;
    if (emit) begin
      acc_shifted   = acc >> OUT_W;
      count_shifted = count - CNT_W'(OUT_W);
    end
    acc_next   = acc_shifted;
    count_next = count_shifted;
    if (accept) begin
      acc_next   = acc_shifted | (ACC_W'(in_data) << count_shifted);
      count_next = count_shifted + CNT_W'(IN_W);
    end else if (pad) begin
      count_next = CNT_W'(OUT_W);
    end
  end

  // State register; reset drops every held bit including a pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      count <= '0;
    end else begin
      acc   <= acc_next;
      count <= count_next;
    end
  end

endmodule

// File: rtl/interface_packer.sv
// interface_packer
// Transmit-side gearbox: packs 10-bit samples LSB-first into 16-bit link
// words (8 samples -> 5 words), valid/ready handshakes on both sides.
// Optional feature macro: INTERFACE_PACKER_FLUSH_EN adds the flush input,
// which zero-pads a partial word so it can be emitted.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_data/in_valid     sample stream in
//   in_ready             sample accepted when in_valid && in_ready
//   out_data/out_valid   packed word out (driven straight from registers)
//   out_ready            word consumed when out_valid && out_ready
//   empty                no bits held
//   flush                (INTERFACE_PACKER_FLUSH_EN only) pad and emit partial word
module interface_packer
  import interface_pkg::*;
#(
  parameter int IN_W  = IN_W_DEFAULT,
  parameter int OUT_W = OUT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             empty
`ifdef INTERFACE_PACKER_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  localparam int CNT_W = count_width(IN_W, OUT_W);

  logic [CNT_W-1:0] count;
  logic             accept;
  logic             emit;
  logic             pad;

  // Output side is a pure decode of the accumulator registers, so there is
  // no combinational path from the input handshake to out_data/out_valid.
  assign out_valid = (count >= CNT_W'(OUT_W));
  assign empty     = (count == '0);

`ifdef INTERFACE_PACKER_FLUSH_EN
  // Flush blocks new samples so the partial word cannot grow while it is
  // being padded; padding applies only when no full word is waiting.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign pad      = flush && !empty && !out_valid;
`else
  assign in_ready = !out_valid || out_ready;
  assign pad      = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign emit   = out_valid && out_ready;

  interface_packer_acc #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_acc (
    .clk     (clk),
    .rst     (rst),
    .accept  (accept),
    .emit    (emit),
    .pad     (pad),
    .in_data (in_data),
    .word    (out_data),
    .count   (count)
  );

endmodule

// File: tb/tb_interface_packer.sv
// tb_interface_packer
// Directed plus random stimulus for interface_packer with a bit-stream
// scoreboard: accepted samples are appended LSB-first to a bit queue and
// every completed 16 bits become an expected word.
module tb_interface_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        empty;
`ifdef INTERFACE_PACKER_FLUSH_EN
  logic        flush;
`endif

  int compared   = 0;
  int mismatched = 0;
  int accepts    = 0;

  bit          model_bits[$];
  logic [15:0] exp_q[$];
  logic [15:0] seen_q[$];
  bit          prev_stall;
  logic [15:0] prev_data;

  logic [15:0] frame_words [5] = '{16'h0801, 16'h0030, 16'h0501, 16'h7018, 16'h0200};

  always #5 clk = ~clk;

  interface_packer dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .empty     (empty)
`ifdef INTERFACE_PACKER_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  // Compare one observed value against its expected value.
  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: plain bit concatenation, 16 bits at a time.
  task automatic modelWords();
    logic [15:0] w;
    while (model_bits.size() >= 16) begin
      for (int b = 0; b < 16; b++) w[b] = model_bits.pop_front();
      exp_q.push_back(w);
    end
  endtask

  task automatic modelPush(input logic [9:0] d);
    for (int b = 0; b < 10; b++) model_bits.push_back(d[b]);
    modelWords();
  endtask

  task automatic modelPad();
    while (model_bits.size() < 16) model_bits.push_back(1'b0);
    modelWords();
  endtask

  // Observe handshakes at the falling edge, between active edges.
  task automatic checkOutput();
    logic [31:0] exp_w;
    if (prev_stall) begin
      checkValue("hold_valid", {31'b0, out_valid}, 32'd1);
      checkValue("hold_data", {16'b0, out_data}, {16'b0, prev_data});
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    if (out_valid && out_ready) begin
      exp_w = 'x;
      if (exp_q.size() > 0) exp_w = {16'b0, exp_q.pop_front()};
      checkValue("word", {16'b0, out_data}, exp_w);
      seen_q.push_back(out_data);
    end
    if (in_valid && in_ready) begin
      modelPush(in_data);
      accepts++;
    end
`ifdef INTERFACE_PACKER_FLUSH_EN
    if (flush && model_bits.size() > 0 && model_bits.size() < 16) modelPad();
`endif
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the active edge.
  task automatic applyStimulus(input bit v, input logic [9:0] d, input bit r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_bits.delete();
    exp_q.delete();
    seen_q.delete();
    prev_stall = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && (exp_q.size() > 0 || !empty); n++) applyStimulus(1'b0, 10'h0, 1'b1);
    checkValue("drain_left", exp_q.size(), 0);
    checkValue("drain_empty", {31'b0, empty}, 32'd1);
  endtask

  task automatic checkFrame(input string tag);
    logic [31:0] obs;
    checkValue({tag, "_count"}, seen_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      obs = 'x;
      if (i < seen_q.size()) obs = {16'b0, seen_q[i]};
      checkValue($sformatf("%s_w%0d", tag, i), obs, {16'b0, frame_words[i]});
    end
  endtask

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
`ifdef INTERFACE_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkValue("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("rst_empty", {31'b0, empty}, 32'd1);
    checkValue("rst_in_ready", {31'b0, in_ready}, 32'd1);
    checkValue("rst_out_data", {16'b0, out_data}, 32'd0);

    // Frame: 0x001..0x008 at full rate
    $display("[TB] frame");
    for (int i = 1; i <= 8; i++) begin
      applyStimulus(1'b1, 10'(i), 1'b1);
      if (i == 2) begin
        checkValue("latency_valid", {31'b0, out_valid}, 32'd1);
        checkValue("latency_data", {16'b0, out_data}, 32'h0801);
      end
    end
    drain();
    checkFrame("frame");

    // All ones: no in_ready drop at full rate
    $display("[TB] all-ones");
    seen_q.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 10'h3FF, 1'b1);
      checkValue("ones_in_ready", {31'b0, in_ready}, 32'd1);
    end
    drain();
    checkValue("ones_count", seen_q.size(), 5);
    for (int i = 0; i < 5 && i < seen_q.size(); i++) checkValue("ones_word", {16'b0, seen_q[i]}, 32'hFFFF);

    // Backpressure after the first word
    $display("[TB] backpressure");
    seen_q.delete();
    applyStimulus(1'b1, 10'd1, 1'b1);
    applyStimulus(1'b1, 10'd2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 10'd3, 1'b0);
      checkValue("bp_in_ready", {31'b0, in_ready}, 32'd0);
      checkValue("bp_valid", {31'b0, out_valid}, 32'd1);
      checkValue("bp_data", {16'b0, out_data}, 32'h0801);
    end
    for (int i = 3; i <= 8; i++) applyStimulus(1'b1, 10'(i), 1'b1);
    drain();
    checkFrame("bp");

`ifdef INTERFACE_PACKER_FLUSH_EN
    // Flush a partial word
    $display("[TB] flush");
    seen_q.delete();
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 10'h3FF, 1'b1);
    flush = 1'b1;
    for (int n = 0; n < 10 && !empty; n++) begin
      applyStimulus(1'b0, 10'h0, 1'b1);
      checkValue("flush_in_ready", {31'b0, in_ready}, 32'd0);
    end
    checkValue("flush_empty", {31'b0, empty}, 32'd1);
    flush = 1'b0;
    drain();
    checkValue("flush_count", seen_q.size(), 2);
    if (seen_q.size() == 2) begin
      checkValue("flush_w0", {16'b0, seen_q[0]}, 32'hFFFF);
      checkValue("flush_w1", {16'b0, seen_q[1]}, 32'h3FFF);
    end
`endif

    // Reset mid-stream with a word pending
    $display("[TB] reset mid-stream");
    applyStimulus(1'b1, 10'd1, 1'b0);
    applyStimulus(1'b1, 10'd2, 1'b0);
    applyStimulus(1'b1, 10'd3, 1'b0);
    doReset();
    checkValue("mrst_out_valid", {31'b0, out_valid}, 32'd0);
    checkValue("mrst_empty", {31'b0, empty}, 32'd1);
    for (int i = 1; i <= 8; i++) applyStimulus(1'b1, 10'(i), 1'b1);
    drain();
    checkFrame("mrst");

    // Random handshakes over 1000 samples
    $display("[TB] random");
    doReset();
    accepts = 0;
    for (int n = 0; n < 6000 && accepts < 1000; n++)
      applyStimulus($urandom_range(0, 9) < 7, 10'($urandom_range(0, 1023)), $urandom_range(0, 9) < 7);
    checkValue("rand_accepts", accepts, 1000);
    drain();
    checkValue("rand_words", seen_q.size(), 625);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
